// File: rtl/executor_commit_rows_pkg.sv
// executor_commit_rows_pkg: shared types for the row-by-row piece commit executor
package executor_commit_rows_pkg;
  localparam int width_c = 16;
  localparam int height_c = 32;
  localparam int shape_dim_c = 4;
  typedef struct packed {
    logic [$clog2(width_c)-1:0] x_m;
    logic [$clog2(height_c)-1:0] y_m;
  } point_t;
  typedef struct packed {
    logic [shape_dim_c-1:0] full_rows;
    logic [$clog2(shape_dim_c+1)-1:0] full_cnt;
    logic collide;
    logic clip;
  } commit_result_t;
endpackage

// File: rtl/commit_row_merge.sv
// commit_row_merge: merges one shape row into one matrix row at column offset x
module commit_row_merge #(
  parameter int width_p = 16,
  parameter int shape_dim_p = 4
) (
  input  logic [width_p-1:0]         rd_row,
  input  logic [shape_dim_p-1:0]     shape_row,
  input  logic [$clog2(width_p)-1:0] x,
  output logic [width_p-1:0]         merged,
  output logic                       full,
  output logic                       collide,
  output logic                       clip
);
  logic [width_p+shape_dim_p-1:0] shifted;
  // widened so cells pushed past the right edge are detectable instead of lost
  assign shifted = {{width_p{1'b0}}, shape_row} << x;
  assign merged = rd_row | shifted[width_p-1:0];
  assign full = &merged;
  assign collide = |(rd_row & shifted[width_p-1:0]);
  assign clip = |shifted[width_p+shape_dim_p-1:width_p];
endmodule

// File: rtl/executor_commit_rows.sv
// executor_commit_rows: read-modify-write commit of a locked piece into the playfield matrix
module executor_commit_rows
  import executor_commit_rows_pkg::*;
#(
  parameter int width_p = width_c,
  parameter int height_p = height_c,
  parameter int shape_dim_p = shape_dim_c,
  localparam int aw = $clog2(height_p),
  localparam int rw = $clog2(shape_dim_p),
  localparam int cw = $clog2(shape_dim_p+1)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_ni,
  input  logic                                    v_i,
  output logic                                    ready_o,
  input  point_t                                  pos_i,
  input  logic [shape_dim_p-1:0][shape_dim_p-1:0] shape_i,
  output logic                                    mm_rd_v_o,
  output logic [aw-1:0]                           mm_rd_addr_o,
  input  logic                                    mm_rd_data_v_i,
  input  logic [width_p-1:0]                      mm_rd_data_i,
  output logic                                    mm_wr_v_o,
  output logic [aw-1:0]                           mm_wr_addr_o,
  output logic [width_p-1:0]                      mm_wr_data_o,
  input  logic                                    mm_wr_ready_i,
  output logic                                    done_o,
  output logic [shape_dim_p-1:0]                  full_rows_o,
  output logic [cw-1:0]                           full_cnt_o,
  output logic                                    collide_o,
  output logic                                    clip_o
);
  localparam logic [2:0] s_idle  = 3'd0;
  localparam logic [2:0] s_scan  = 3'd1;
  localparam logic [2:0] s_read  = 3'd2;
  localparam logic [2:0] s_wait  = 3'd3;
  localparam logic [2:0] s_write = 3'd4;
  localparam logic [2:0] s_done  = 3'd5;
  logic [2:0] state;
  logic [rw-1:0] r;
  point_t pos_q;
  logic [shape_dim_p-1:0][shape_dim_p-1:0] shape_q;
  logic [width_p-1:0] merged_q, merged;
  commit_result_t res_q;
  logic [aw:0] addr;
  logic row_zero, row_oob, last, full, collide, clip;
  // one extra address bit so rows below the bottom edge are seen as out of range, not wrapped
  assign addr = {1'b0, pos_q.y_m} + (aw+1)'(r);
  assign row_zero = ~|shape_q[r];
  assign row_oob = addr >= (aw+1)'(height_p);
  assign last = r == rw'(shape_dim_p-1);
  commit_row_merge #(.width_p(width_p), .shape_dim_p(shape_dim_p)) u_merge (
    .rd_row(mm_rd_data_i),
    .shape_row(shape_q[r]),
    .x(pos_q.x_m),
    .merged(merged),
    .full(full),
    .collide(collide),
    .clip(clip)
  );
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state <= s_idle;
      r <= '0;
      pos_q <= '0;
      shape_q <= '0;
      merged_q <= '0;
      res_q <= '0;
    end else begin
      case (state)
        s_idle: if (v_i) begin
          state <= s_scan;
          pos_q <= pos_i;
          shape_q <= shape_i;
          r <= '0;
          res_q <= '0;
        end
        s_scan: if (row_zero || row_oob) begin
          res_q.clip <= res_q.clip | ~row_zero;
          state <= last ? s_done : s_scan;
          r <= last ? r : r + 1'b1;
        end else state <= s_read;
        s_read: state <= s_wait;
        s_wait: if (mm_rd_data_v_i) begin
          merged_q <= merged;
          res_q.collide <= res_q.collide | collide;
          res_q.clip <= res_q.clip | clip;
          res_q.full_rows[r] <= full;
          res_q.full_cnt <= res_q.full_cnt + cw'(full);
          state <= s_write;
        end
        s_write: if (mm_wr_ready_i) begin
          state <= last ? s_done : s_scan;
          r <= last ? r : r + 1'b1;
        end
        default: state <= s_idle;
      endcase
    end
  end
  assign ready_o = state == s_idle;
  assign mm_rd_v_o = state == s_read;
  assign mm_rd_addr_o = addr[aw-1:0];
  assign mm_wr_v_o = state == s_write;
  assign mm_wr_addr_o = addr[aw-1:0];
  assign mm_wr_data_o = merged_q;
  assign done_o = state == s_done;
  assign full_rows_o = res_q.full_rows;
  assign full_cnt_o = res_q.full_cnt;
  assign collide_o = res_q.collide;
  assign clip_o = res_q.clip;
endmodule

// File: tb/tb_executor_commit_rows.sv
// tb_executor_commit_rows: randomized scoreboard bench with a cell-level reference model
module tb_executor_commit_rows;
  import executor_commit_rows_pkg::*;
  localparam int W = 16;
  localparam int H = 32;
  localparam int D = 4;
  typedef logic [D-1:0][D-1:0] shape_t;
  logic clk = 0, reset_ni = 0, v_i = 0;
  logic ready_o, mm_rd_v_o, mm_wr_v_o, done_o, collide_o, clip_o;
  point_t pos_i = '0;
  shape_t shape_i = '0;
  logic [4:0] mm_rd_addr_o, mm_wr_addr_o;
  logic mm_rd_data_v_i = 0, mm_wr_ready_i = 0;
  logic [W-1:0] mm_rd_data_i = '0, mm_wr_data_o;
  logic [D-1:0] full_rows_o;
  logic [2:0] full_cnt_o;
  executor_commit_rows dut (
    .clk_i(clk), .reset_ni(reset_ni), .v_i(v_i), .ready_o(ready_o),
    .pos_i(pos_i), .shape_i(shape_i),
    .mm_rd_v_o(mm_rd_v_o), .mm_rd_addr_o(mm_rd_addr_o),
    .mm_rd_data_v_i(mm_rd_data_v_i), .mm_rd_data_i(mm_rd_data_i),
    .mm_wr_v_o(mm_wr_v_o), .mm_wr_addr_o(mm_wr_addr_o), .mm_wr_data_o(mm_wr_data_o),
    .mm_wr_ready_i(mm_wr_ready_i), .done_o(done_o), .full_rows_o(full_rows_o),
    .full_cnt_o(full_cnt_o), .collide_o(collide_o), .clip_o(clip_o)
  );
  always #5 clk = ~clk;
  logic [W-1:0] mem [H];
  logic [W-1:0] ref_mem [H];
  logic [W-1:0] save [H];
  int exp_rd[$];
  logic [31:0] exp_wr[$];
  logic [8:0] exp_res[$];
  int checks = 0, errors = 0, done_cnt = 0;
  int rd_lat = 1, rd_cnt = 0, stall_len = 0, stall_left = 0;
  logic [4:0] rd_addr = '0;
  logic rand_ready = 0, mon_en = 0, noise = 0, stalled = 0;
  logic [20:0] hold = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with nothing expected", name);
  endtask

  // reference: walk every shape cell, place it on the matrix copy, note overlaps and drops
  task automatic model(input int x, input int y, input shape_t sh);
    logic [D-1:0] fr;
    logic col, clp;
    logic [W-1:0] row;
    fr = '0; col = 0; clp = 0;
    for (int r = 0; r < D; r++) begin
      if (sh[r] == '0) continue;
      if (y + r >= H) begin clp = 1; continue; end
      row = ref_mem[5'(y + r)];
      for (int c = 0; c < D; c++)
        if (sh[r][c]) begin
          if (x + c >= W) clp = 1;
          else begin
            if (row[4'(x + c)]) col = 1;
            row[4'(x + c)] = 1'b1;
          end
        end
      ref_mem[5'(y + r)] = row;
      exp_rd.push_back(y + r);
      exp_wr.push_back({16'(y + r), row});
      fr[r] = &row;
    end
    exp_res.push_back({fr, 3'($countones(fr)), col, clp});
  endtask

  task automatic preset(input int a, input logic [W-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic commit(input int x, input int y, input shape_t sh, output int lat);
    int n;
    model(x, y, sh);
    @(negedge clk);
    v_i = 1; pos_i.x_m = x[3:0]; pos_i.y_m = y[4:0]; shape_i = sh;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      v_i = (noise && n > 1) ? ($urandom_range(2) == 0) : 1'b0;
    end while (!done_o && n < 500);
    v_i = 0;
    lat = n;
    if (!done_o) begin
      checks++; errors++;
      $display("FAIL commit_timeout: no done_o after %0d cycles", n);
    end
    check("wr_drained", 32'(exp_wr.size()), 0);
  endtask

  // memory responder plus scoreboard monitor, all sampled on the falling edge
  initial forever begin
    @(negedge clk);
    mm_rd_data_v_i = 0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin mm_rd_data_v_i = 1; mm_rd_data_i = mem[rd_addr]; end
    end
    if (mm_rd_v_o) begin rd_addr = mm_rd_addr_o; rd_cnt = rd_lat; end
    if (mm_wr_v_o) begin
      if (stall_left > 0) begin mm_wr_ready_i = 0; stall_left--; end
      else mm_wr_ready_i = rand_ready ? ($urandom_range(2) != 0) : 1'b1;
    end else mm_wr_ready_i = 0;
    if (mm_wr_v_o && mm_wr_ready_i) begin
      mem[mm_wr_addr_o] = mm_wr_data_o;
      stall_left = stall_len;
    end
    if (!mon_en) stalled = 0;
    else begin
      if (stalled) check("wr_stable", 32'({mm_wr_v_o, mm_wr_addr_o, mm_wr_data_o}), 32'({1'b1, hold}));
      if (mm_rd_v_o) begin
        if (exp_rd.size() == 0) unexpected("rd");
        else check("rd_addr", 32'(mm_rd_addr_o), exp_rd.pop_front());
      end
      if (mm_wr_v_o && mm_wr_ready_i) begin
        if (exp_wr.size() == 0) unexpected("wr");
        else begin
          logic [31:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(mm_wr_addr_o), 32'(e[31:16]));
          check("wr_data", 32'(mm_wr_data_o), 32'(e[15:0]));
        end
      end
      if (done_o) begin
        done_cnt++;
        if (exp_res.size() == 0) unexpected("done");
        else check("result", 32'({full_rows_o, full_cnt_o, collide_o, clip_o}), 32'(exp_res.pop_front()));
      end
      stalled = mm_wr_v_o && !mm_wr_ready_i;
      hold = {mm_wr_addr_o, mm_wr_data_o};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, n, d0;
    for (int i = 0; i < H; i++) preset(i, '0);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_pulses", 32'({mm_rd_v_o, mm_wr_v_o, done_o}), 0);
    check("rst_results", 32'({full_rows_o, full_cnt_o, collide_o, clip_o}), 0);
    reset_ni = 1;
    mon_en = 1;
    commit(3, 10, 16'h00F0, lat);
    check("t1_row11", 32'(mem[11]), 32'h0078);
    check("t1_flags", 32'({full_rows_o, collide_o, clip_o}), 0);
    preset(20, 16'hFF0F); preset(21, 16'hFFCF);
    commit(4, 20, 16'h0033, lat);
    check("t2_row20", 32'(mem[20]), 32'hFF3F);
    check("t2_row21", 32'(mem[21]), 32'hFFFF);
    check("t2_full", 32'({full_rows_o, full_cnt_o}), 32'({4'b0010, 3'd1}));
    preset(5, 16'h0010);
    commit(4, 5, 16'h0001, lat);
    check("t3_collide", 32'(collide_o), 1);
    check("t3_row5", 32'(mem[5]), 32'h0010);
    commit(14, 0, 16'h0008, lat);
    check("t4_row0", 32'(mem[0]), 0);
    check("t4_clip", 32'(clip_o), 1);
    commit(0, 30, 16'h6600, lat);
    check("t4_clip_bottom", 32'(clip_o), 1);
    rd_lat = 3; stall_len = 4; stall_left = 4;
    d0 = done_cnt;
    commit(2, 12, 16'h0660, lat);
    repeat (10) @(negedge clk);
    check("t5_done_once", 32'(done_cnt - d0), 1);
    check("t5_held", 32'({full_rows_o, full_cnt_o, collide_o, clip_o}), 0);
    // reset while a stalled write is held
    rd_lat = 1; stall_len = 20; stall_left = 20;
    preset(2, '0);
    save = ref_mem;
    model(0, 2, 16'h000F);
    @(negedge clk);
    v_i = 1; pos_i.x_m = 4'd0; pos_i.y_m = 5'd2; shape_i = 16'h000F;
    n = 0;
    do begin @(negedge clk); n++; v_i = 0; end while (!mm_wr_v_o && n < 50);
    check("t6_reached_write", 32'(mm_wr_v_o), 1);
    reset_ni = 0; mon_en = 0;
    @(negedge clk);
    check("t6_ready", 32'(ready_o), 1);
    check("t6_pulses", 32'({mm_rd_v_o, mm_wr_v_o, done_o}), 0);
    check("t6_results", 32'({full_rows_o, full_cnt_o, collide_o, clip_o}), 0);
    exp_rd.delete(); exp_wr.delete(); exp_res.delete();
    ref_mem = save;
    reset_ni = 1;
    @(negedge clk);
    stall_len = 0; stall_left = 0; mon_en = 1;
    repeat (8) @(negedge clk);
    check("t6_dropped_write", 32'(mem[2]), 0);
    commit(5, 7, 16'h0000, lat);
    check("t6_zero_latency", 32'(lat), D + 1);
    rand_ready = 1; noise = 1;
    for (int k = 0; k < 60; k++) begin
      int x, y;
      x = $urandom_range(15);
      y = $urandom_range(31);
      rd_lat = $urandom_range(4, 1);
      for (int r = 0; r < D; r++)
        if (y + r < H)
          case ($urandom_range(3))
            0: preset(y + r, '0);
            1: preset(y + r, W'($urandom));
            2: preset(y + r, ~(W'(1) << $urandom_range(15)));
            default: preset(y + r, {W{1'b1}});
          endcase
      commit(x, y, shape_t'($urandom), lat);
    end
    repeat (5) @(negedge clk);
    check("queues_empty", 32'(exp_rd.size() + exp_wr.size() + exp_res.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
